// File: rtl/flow_match_sched.sv
// flow_match_sched
//   Flow-table match sequencer. One chained equality comparator is shared by
//   every rule. It walks the rule table in ascending index order, one rule per
//   cycle, and returns the index of the first enabled rule that matches the key,
//   or a miss. The control plane programs rules through the cfg_* port while
//   the block is idle.
//
//   Build option: define MATCH_MASK_EN to enable ternary matching. This adds
//   the cfg_mask port and per-rule care-mask storage. Without it, matching is
//   exact on all KEY_W bits.
//
//   Ports:
//     clk, rst_n          clock and asynchronous active-low reset
//     key_valid/ready     key handshake from the header parser (ready only in IDLE)
//     key_data            packet key
//     res_valid/ready     result handshake to the action stage (valid only in DONE)
//     res_hit, res_idx    match flag and first matching index (0 on miss)
//     cfg_we/addr/key/en  rule write port, ignored while cfg_busy
//     cfg_mask            per-bit care mask (MATCH_MASK_EN only)
//     cfg_busy            high while a key is in flight (SCAN or DONE)
module flow_match_sched #(
    parameter int unsigned KEY_W     = 8,
    parameter int unsigned NUM_RULES = 8,
    parameter int unsigned IDX_W     = $clog2(NUM_RULES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_idx,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic             cfg_en,
`ifdef MATCH_MASK_EN
    input  logic [KEY_W-1:0] cfg_mask,
`endif
    output logic             cfg_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               hit_d;
    logic [IDX_W-1:0]   ridx_d;

    logic [KEY_W-1:0]   rule_q [NUM_RULES];
    logic [NUM_RULES-1:0] en_q;
    logic [KEY_W-1:0]   care_c;
    logic               cmp_hit_c;
    logic               last_c;
    logic               cfg_wr_c;

`ifdef MATCH_MASK_EN
    logic [KEY_W-1:0]   mask_q [NUM_RULES];
    assign care_c = mask_q[idx_q];
`else
    assign care_c = '1;
`endif

    // Shared comparator: the rule under the scan pointer, restricted to cared bits
    assign cmp_hit_c = en_q[idx_q] && (((key_q ^ rule_q[idx_q]) & care_c) == '0);
    assign last_c    = (idx_q == IDX_W'(NUM_RULES - 1));
    assign cfg_wr_c  = cfg_we && (state_q == IDLE);

    // Rule table. A write coinciding with a key accept lands before the first compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                rule_q[i] <= '0;
`ifdef MATCH_MASK_EN
                mask_q[i] <= '1;
`endif
            end
            en_q <= '0;
        end else if (cfg_wr_c) begin
            rule_q[cfg_addr] <= cfg_key;
            en_q[cfg_addr]   <= cfg_en;
`ifdef MATCH_MASK_EN
            mask_q[cfg_addr] <= cfg_mask;
`endif
        end
    end

    // State, scan pointer, latched key and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            res_hit   <= 1'b0;
            res_idx   <= '0;
            key_ready <= 1'b1;
            res_valid <= 1'b0;
            cfg_busy  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            res_hit   <= hit_d;
            res_idx   <= ridx_d;
            key_ready <= (state_d == IDLE);
            res_valid <= (state_d == DONE);
            cfg_busy  <= (state_d != IDLE);
        end
    end

    // Next-state logic. The result registers hold their value outside SCAN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_d   = key_q;
        hit_d   = res_hit;
        ridx_d  = res_idx;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_d   = key_data;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cmp_hit_c) begin
                    hit_d   = 1'b1;
                    ridx_d  = idx_q;
                    state_d = DONE;
                end else if (last_c) begin
                    hit_d   = 1'b0;
                    ridx_d  = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
